// File: rtl/rijndael_subbytes_seq.sv
// Folded SubBytes: walks a Rijndael state through NSBOX shared S-box lanes one chunk per cycle,
// yielding the lanes to single-word key-schedule SubWord requests with absolute priority.
module rijndael_subbytes_seq #(
  parameter int unsigned NB    = 4,
  parameter int unsigned NSBOX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*NB-1:0]      in_state,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*NB-1:0]      out_state,
  output logic [8*NSBOX-1:0]    sbox_in,
  input  logic [8*NSBOX-1:0]    sbox_out,
  input  logic                  ks_req,
  input  logic [31:0]           ks_word,
  output logic                  ks_gnt,
  output logic [31:0]           ks_result
);

  localparam int unsigned STATESIZE = 32 * NB;
  localparam int unsigned NCHUNK    = (4 * NB) / NSBOX;
  localparam int unsigned CHUNK_W   = 8 * NSBOX;
  localparam int unsigned CNT_W     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned KS_RUN_W  = 3;
  localparam int unsigned KS_MAX    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [STATESIZE-1:0]   work_q, work_d;
  logic [STATESIZE-1:0]   out_state_q, out_state_d;
  logic                   out_valid_q, out_valid_d;
  logic [KS_RUN_W-1:0]    ks_run_q, ks_run_d;
  logic [CHUNK_W-1:0]     sbox_in_c;
  int unsigned            chunk_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      out_state_q <= '0;
      out_valid_q <= 1'b0;
      ks_run_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      out_state_q <= out_state_d;
      out_valid_q <= out_valid_d;
      ks_run_q    <= ks_run_d;
    end
  end

  // Next-state, chunk write-back and lane steering; a key-schedule request freezes the datapath.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    out_state_d = out_state_q;
    out_valid_d = out_valid_q;
    sbox_in_c   = '0;
    chunk_base  = 32'(cnt_q) * CHUNK_W;

    if (ks_req) begin
      sbox_in_c[31:0] = ks_word;
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_state;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!ks_req) begin
          sbox_in_c                       = work_q[chunk_base +: CHUNK_W];
          work_d[chunk_base +: CHUNK_W]   = sbox_out;
          if (cnt_q == CNT_W'(NCHUNK - 1)) begin
            out_state_d = work_d;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Length of the current unbroken run of key-schedule requests, saturating at the limit.
  always_comb begin
    ks_run_d = '0;
    if (ks_req) begin
      ks_run_d = (ks_run_q >= KS_RUN_W'(KS_MAX)) ? ks_run_q : ks_run_q + KS_RUN_W'(1);
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_state = out_state_q;
  assign sbox_in   = sbox_in_c;
  assign ks_gnt    = ks_req;
  assign ks_result = ks_req ? sbox_out[31:0] : 32'h0;

  // The requester may hold the lanes for at most KS_MAX consecutive cycles.
  ks_starve_a: assert property (@(posedge clk) disable iff (!rst_n)
    ks_req |-> (ks_run_q < KS_RUN_W'(KS_MAX)));

endmodule

// File: tb/tb_rijndael_subbytes_seq.sv
// Bench for rijndael_subbytes_seq: NB=4/NSBOX=4 and NB=8/NSBOX=8 instances driving a table S-box model.
module tb_rijndael_subbytes_seq;

  localparam logic [127:0] SROW [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [127:0] r;
    int c;
    r = SROW[x[7:4]];
    c = 15 - int'(x[3:0]);
    return r[c*8 +: 8];
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ks_req, a_ks_gnt;
  logic [127:0] a_in_state, a_out_state;
  logic [31:0]  a_sbox_in, a_sbox_out, a_ks_word, a_ks_result;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ks_req, b_ks_gnt;
  logic [255:0] b_in_state, b_out_state;
  logic [63:0]  b_sbox_in, b_sbox_out;
  logic [31:0]  b_ks_word, b_ks_result;

  rijndael_subbytes_seq #(.NB(4), .NSBOX(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_state(a_in_state),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_state(a_out_state),
    .sbox_in(a_sbox_in), .sbox_out(a_sbox_out),
    .ks_req(a_ks_req), .ks_word(a_ks_word), .ks_gnt(a_ks_gnt), .ks_result(a_ks_result)
  );

  rijndael_subbytes_seq #(.NB(8), .NSBOX(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_state(b_in_state),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_state(b_out_state),
    .sbox_in(b_sbox_in), .sbox_out(b_sbox_out),
    .ks_req(b_ks_req), .ks_word(b_ks_word), .ks_gnt(b_ks_gnt), .ks_result(b_ks_result)
  );

  always_comb begin
    for (int l = 0; l < 4; l++) a_sbox_out[l*8 +: 8] = sb(a_sbox_in[l*8 +: 8]);
  end
  always_comb begin
    for (int l = 0; l < 8; l++) b_sbox_out[l*8 +: 8] = sb(b_sbox_in[l*8 +: 8]);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer din, then count cycles from the accept edge to out_valid; optional one-cycle ks request at offset ks_at.
  task automatic run4(input logic [127:0] din, input int ks_at, output int lat);
    int w;
    w = 0;
    while (!a_in_ready && w < 20) begin
      step();
      w++;
    end
    a_in_valid = 1'b1;
    a_in_state = din;
    step();
    a_in_valid = 1'b0;
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      if (a_out_valid) begin
        lat = n;
        break;
      end
      if (n == ks_at) begin
        a_ks_req  = 1'b1;
        a_ks_word = 32'h00000053;
        #1;
        chk("ks_gnt", 256'(a_ks_gnt), 256'd1);
        chk("ks_result", 256'(a_ks_result), 256'h636363ED);
        chk("ks_lanes", 256'(a_sbox_in), 256'h00000053);
      end
      step();
      a_ks_req = 1'b0;
    end
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  vec_t vecs [4];
  int   lat;
  int   acc [4];
  int   dn  [4];
  int   n_acc, n_dn;
  logic seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{128'h0, 128'h63636363_63636363_63636363_63636363};
    vecs[1] = '{128'h0f0e0d0c_0b0a0908_07060504_03020100, 128'h76abd7fe_2b670130_c56f6bf2_7b777c63};
    vecs[2] = '{128'h53535353_53535353_53535353_53535353, 128'hedededed_edededed_edededed_edededed};
    vecs[3] = '{128'h1f1e1d1c_1b1a1918_17161514_13121110, 128'hc072a49c_afa2d4ad_f04759fa_7dc982ca};

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_state = '0; a_out_ready = 1'b1; a_ks_req = 1'b0; a_ks_word = '0;
    b_in_valid = 1'b0; b_in_state = '0; b_out_ready = 1'b1; b_ks_req = 1'b0; b_ks_word = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_in_ready", 256'(a_in_ready), 256'd1);
    chk("rst_out_valid", 256'(a_out_valid), 256'd0);
    chk("rst_out_state", 256'(a_out_state), 256'd0);
    chk("rst_sbox_in", 256'(a_sbox_in), 256'd0);
    chk("rst_ks_gnt", 256'(a_ks_gnt), 256'd0);
    chk("rst_b_in_ready", 256'(b_in_ready), 256'd1);
    chk("rst_b_ks", 256'({b_ks_gnt, b_ks_result}), 256'd0);

    // Table-driven vectors, out_ready held high
    for (int i = 0; i < 4; i++) begin
      run4(vecs[i].din, -1, lat);
      chk($sformatf("vec%0d_latency", i), 256'(lat), 256'd4);
      chk($sformatf("vec%0d_state", i), 256'(a_out_state), 256'(vecs[i].dout));
      step();
      chk($sformatf("vec%0d_valid_1cyc", i), 256'(a_out_valid), 256'd0);
      chk($sformatf("vec%0d_ready_back", i), 256'(a_in_ready), 256'd1);
    end
    chk("idle_sbox_in", 256'(a_sbox_in), 256'd0);

    // Key-schedule stall in the second BUSY cycle
    run4(vecs[1].din, 1, lat);
    chk("ks_mid_latency", 256'(lat), 256'd5);
    chk("ks_mid_state", 256'(a_out_state), 256'(vecs[1].dout));
    step();

    // Key-schedule stall on the final chunk
    run4(vecs[3].din, 3, lat);
    chk("ks_last_latency", 256'(lat), 256'd5);
    chk("ks_last_state", 256'(a_out_state), 256'(vecs[3].dout));
    step();

    // Grant while idle
    a_ks_req = 1'b1; a_ks_word = 32'h00530000;
    #1;
    chk("ks_idle_lanes", 256'(a_sbox_in), 256'h00530000);
    chk("ks_idle_result", 256'(a_ks_result), 256'h63ED6363);
    step();
    a_ks_req = 1'b0;

    // Back-pressure: result held, second input ignored
    a_out_ready = 1'b0;
    run4(vecs[1].din, -1, lat);
    chk("bp_latency", 256'(lat), 256'd4);
    for (int k = 0; k < 10; k++) begin
      a_in_valid = 1'b1;
      a_in_state = vecs[2].din;
      #1;
      chk("bp_valid", 256'(a_out_valid), 256'd1);
      chk("bp_state", 256'(a_out_state), 256'(vecs[1].dout));
      chk("bp_in_ready", 256'(a_in_ready), 256'd0);
      step();
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    step();
    chk("bp_release_valid", 256'(a_out_valid), 256'd0);
    chk("bp_release_ready", 256'(a_in_ready), 256'd1);
    chk("bp_release_state", 256'(a_out_state), 256'(vecs[1].dout));
    run4(vecs[3].din, -1, lat);
    chk("bp_next_latency", 256'(lat), 256'd4);
    chk("bp_next_state", 256'(a_out_state), 256'(vecs[3].dout));
    step();

    // Reset during BUSY with counter = 2
    a_in_valid = 1'b1;
    a_in_state = vecs[2].din;
    step();
    a_in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 256'(a_out_valid), 256'd0);
    chk("midrst_ready", 256'(a_in_ready), 256'd1);
    chk("midrst_state", 256'(a_out_state), 256'd0);
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (a_out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", 256'(seen), 256'd0);
    chk("midrst_ready_after", 256'(a_in_ready), 256'd1);
    run4(vecs[0].din, -1, lat);
    chk("midrst_fresh_latency", 256'(lat), 256'd4);
    chk("midrst_fresh_state", 256'(a_out_state), 256'(vecs[0].dout));
    step();

    // NB=8, NSBOX=8: back-to-back all-0x53 states
    for (int k = 0; k < 4; k++) begin
      acc[k] = -100;
      dn[k]  = -100;
    end
    n_acc = 0;
    n_dn  = 0;
    b_in_valid = 1'b1;
    b_in_state = {32{8'h53}};
    for (int c = 0; c < 30; c++) begin
      if (b_in_ready && n_acc < 4) begin
        acc[n_acc] = c;
        n_acc++;
      end
      if (b_out_valid && n_dn < 4) begin
        dn[n_dn] = c;
        n_dn++;
        chk("b_state", b_out_state, {32{8'hED}});
      end
      step();
    end
    b_in_valid = 1'b0;
    chk("b_latency", 256'(dn[0] - acc[0] - 1), 256'd4);
    chk("b_period0", 256'(acc[1] - acc[0]), 256'd6);
    chk("b_period1", 256'(acc[2] - acc[1]), 256'd6);
    chk("b_done_period", 256'(dn[1] - dn[0]), 256'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
